// File: rtl/timer_counter_if.sv
// Bridge-side bus bundle for the timer/counter peripheral: word offset, write
// strobe and data toward the device; read data and interrupt request back.
interface timer_counter_if;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (output Addr, WE, Din, input Dout, IRQ);
    modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter: CTRL/PRESET/COUNT registers on the
// bridge bus and a level interrupt request raised when the count expires.
module timer_counter (
    input  logic           clk,
    input  logic           reset,
    timer_counter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'b00;
    localparam logic [1:0] ADDR_PRESET = 2'b01;
    localparam logic [1:0] ADDR_COUNT  = 2'b10;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;      // {IM, Mode[1:0], En}
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;
    logic        irq_q, irq_d;
    logic [31:0] dout;

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            S_IDLE: begin
                if (ctrl_q[0]) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = 32'd0;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                if (ctrl_q[2:1] == 2'b01) begin
                    state_d = S_LOAD;
                end else begin
                    irq_flag_d = 1'b1;
                    ctrl_d[0]  = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Software writes override the FSM's own CTRL/flag updates; the state
        // transition above still uses the pre-edge register values.
        if (bus.WE) begin
            case (bus.Addr)
                ADDR_CTRL: begin
                    ctrl_d     = bus.Din[3:0];
                    irq_flag_d = 1'b0;
                end
                ADDR_PRESET: begin
                    preset_d   = bus.Din;
                    irq_flag_d = 1'b0;
                end
                default: ;
            endcase
        end

        irq_d = irq_flag_d & ctrl_d[3];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        case (bus.Addr)
            ADDR_CTRL:   dout = {28'd0, ctrl_q};
            ADDR_PRESET: dout = preset_q;
            ADDR_COUNT:  dout = count_q;
            default:     dout = 32'd0;
        endcase
    end

    assign bus.Dout = dout;
    assign bus.IRQ  = irq_q;
endmodule
